// File: rtl/count_checker.sv
// Sequence checker for a sampled free-running 32-bit up-counter: acquires lock,
// flags breaks while locked. Optional macro COUNT_CHECKER_STALL_EN treats repeats as stalls.
module count_checker #(
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [31:0]      count_in,
  input  logic             count_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      last_count
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  localparam logic [3:0] THRESH = 4'(LOCK_THRESH);

  state_t           state, state_nxt;
  logic [3:0]       match_cnt, match_nxt;
  logic             in_seq;
  logic             stall;
  logic             brk;
  logic             locked_nxt;
  logic             err_pulse_nxt;
  logic [ERR_W-1:0] err_count_nxt;
  logic [31:0]      last_count_nxt;

  // Modulo-2^32 add makes 0xFFFFFFFF -> 0 in sequence for free.
  assign in_seq = (count_in == last_count + 32'd1);

`ifdef COUNT_CHECKER_STALL_EN
  // A repeated value is a counter stall; IDLE still captures unconditionally.
  assign stall = count_valid && (state != IDLE) && (count_in == last_count);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    brk       = 1'b0;
    if (count_valid && !stall) begin
      case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          match_nxt = 4'd1;
        end
        ACQUIRE, LOST: begin
          if (in_seq) begin
            match_nxt = match_cnt + 4'd1;
            if (match_cnt + 4'd1 >= THRESH) state_nxt = LOCKED;
          end else begin
            match_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (!in_seq) begin
            brk       = 1'b1;
            state_nxt = LOST;
            match_nxt = 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      endcase
    end
  end

  // Output values are computed from the next state so the registered
  // outputs line up with the state register one cycle after the sample.
  always_comb begin
    locked_nxt     = (state_nxt == LOCKED);
    err_pulse_nxt  = brk;
    err_count_nxt  = err_count;
    if (brk && (err_count != '1)) err_count_nxt = err_count + 1'b1;
    last_count_nxt = (count_valid && !stall) ? count_in : last_count;
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      last_count <= '0;
    end else begin
      locked     <= locked_nxt;
      err_pulse  <= err_pulse_nxt;
      err_count  <= err_count_nxt;
      last_count <= last_count_nxt;
    end
  end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The block SHALL have parameter LOCK_THRESH, default 4, giving the number of consecutive in-sequence samples required to declare lock (legal range 2..15).
REQ-002 The block SHALL have parameter ERR_W, default 16, giving the width of the error counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_l, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The block SHALL have port count_in, input, 32 bits: the sampled value from a free-running up-counter.
REQ-006 The block SHALL have port count_valid, input, 1 bit: when high, count_in is a sample to check on this edge.
REQ-007 The block SHALL have port locked, output, 1 bit: the block is tracking an in-sequence stream.
REQ-008 The block SHALL have port err_pulse, output, 1 bit: a one-cycle pulse on each sequence break while locked.
REQ-009 The block SHALL have port err_count, output, ERR_W bits: the number of sequence breaks detected while locked, saturating.
REQ-010 The block SHALL have port last_count, output, 32 bits: the most recent accepted sample.

Function
REQ-011 The block SHALL implement FSM states IDLE, ACQUIRE, LOCKED and LOST; locked SHALL be 1 only in LOCKED.
REQ-012 When count_valid is low, the block SHALL keep its state, its match counter and last_count unchanged, and SHALL hold err_pulse at 0.
REQ-013 A sample SHALL be "in sequence" when count_in == last_count + 1, computed modulo 2^32; 0xFFFFFFFF followed by 0x00000000 SHALL count as in sequence.
REQ-014 In IDLE, a valid sample SHALL be captured into last_count, set the match counter to 1, and move the FSM to ACQUIRE.
REQ-015 In ACQUIRE or LOST, an in-sequence sample SHALL increment the match counter; when the match counter reaches LOCK_THRESH, the FSM SHALL move to LOCKED.
REQ-016 In ACQUIRE or LOST, an out-of-sequence sample SHALL set the match counter to 1 and keep the current state; it SHALL produce no err_pulse and no err_count change.
REQ-017 In LOCKED, an in-sequence sample SHALL keep the FSM in LOCKED.
REQ-018 In LOCKED, an out-of-sequence sample SHALL assert err_pulse on the next cycle, increment err_count (saturating at all-ones), move the FSM to LOST and set the match counter to 1.
REQ-019 Every valid sample SHALL update last_count, whether or not it is in sequence.
REQ-020 All outputs SHALL be registered: locked, err_pulse and err_count SHALL reflect a sample one cycle after the edge on which it was presented.
REQ-021 err_pulse SHALL never stay high for two consecutive cycles unless a break is detected on each of those cycles; a LOST-to-LOCKED-to-break sequence SHALL pulse again.

Reset
REQ-022 While reset_l is low at a rising clk edge, the block SHALL set the FSM to IDLE, the match counter to 0, locked to 0, err_pulse to 0, err_count to 0 and last_count to 0x00000000.
REQ-023 Reset SHALL take priority over count_valid.
REQ-024 Reset asserted in any state, including mid-acquire, SHALL discard all history, so that the first valid sample after release is treated as in IDLE.

Configuration
REQ-025 When macro COUNT_CHECKER_STALL_EN is defined, a sample equal to last_count SHALL be treated as a stall: no state change, no match-counter change, no error, and last_count unchanged.
REQ-026 When COUNT_CHECKER_STALL_EN is undefined, a sample equal to last_count SHALL be treated as out of sequence under REQ-016 and REQ-018.

Verification
REQ-027 Bench SHALL cover lock: reset, then valid samples 10, 11, 12, 13 -> locked=1 the cycle after 13; err_count=0.
REQ-028 Bench SHALL cover wrap: lock on 0xFFFFFFFD..0x00000000 -> locked=1, no err_pulse across the wrap.
REQ-029 Bench SHALL cover a break: while locked at 20, present 25 -> err_pulse=1 for exactly one cycle, err_count=1, locked=0; then 26, 27, 28 -> locked=1 again.
REQ-030 Bench SHALL cover gaps: while locked, drop count_valid low for 5 cycles, then present last_count+1 -> no error, locked stays 1.
REQ-031 Bench SHALL cover reset mid-acquire: samples 5, 6, reset_l low for 1 cycle, then 7, 8, 9 -> locked stays 0 (3 matches < 4); a further 10 -> locked=1.
REQ-032 Bench SHALL cover repeats: while locked at 40, present 40 -> with COUNT_CHECKER_STALL_EN no error; without it err_pulse=1 and err_count increments.
